// File: rtl/m3_block_scheduler.sv
// Milestone 3 block sequencer: overlaps the decoder (producer) and IDCT (consumer)
// over all 8x8 blocks through two ping-pong DP-RAM banks, and issues block indices.
module m3_block_scheduler #(
    parameter int NUM_BLOCKS = 2400,
    parameter int IDX_W      = 12
) (
    input  logic             Clock_50,
    input  logic             Resetn,
    input  logic             start,
    output logic             finish,
    output logic             dec_start,
    input  logic             dec_finish,
    output logic             dec_bank,
    output logic [IDX_W-1:0] dec_blk_idx,
    output logic             idct_start,
    input  logic             idct_finish,
    output logic             idct_bank,
    output logic [IDX_W-1:0] idct_blk_idx,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LP_NUM = IDX_W'(NUM_BLOCKS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [1:0]       r_bank_full;
    logic             r_dec_busy, r_idct_busy;
    logic             r_dec_bank, r_idct_bank;
    logic [IDX_W-1:0] r_dec_cnt, r_idct_cnt;
    logic             r_dec_start, r_idct_start, r_finish, r_busy;

    logic             w_run, w_dec_done, w_idct_done, w_last;
    logic [1:0]       w_bank_full;
    logic             w_dec_bank, w_idct_bank, w_dec_busy, w_idct_busy;
    logic [IDX_W-1:0] w_dec_cnt, w_idct_cnt;
    logic             w_dec_issue, w_idct_issue;

    // Issue decisions look at post-completion state so a start follows a finish by one cycle.
    always_comb begin
        w_run       = (r_state == S_RUN);
        w_dec_done  = w_run && r_dec_busy && dec_finish;
        w_idct_done = w_run && r_idct_busy && idct_finish;
        w_bank_full = r_bank_full;
        if (w_idct_done) w_bank_full[r_idct_bank] = 1'b0;
        if (w_dec_done)  w_bank_full[r_dec_bank]  = 1'b1;
        w_dec_bank   = r_dec_bank ^ w_dec_done;
        w_idct_bank  = r_idct_bank ^ w_idct_done;
        w_dec_busy   = r_dec_busy & ~w_dec_done;
        w_idct_busy  = r_idct_busy & ~w_idct_done;
        w_dec_cnt    = r_dec_cnt + IDX_W'(w_dec_done);
        w_idct_cnt   = r_idct_cnt + IDX_W'(w_idct_done);
        w_last       = (w_idct_cnt == LP_NUM);
        w_dec_issue  = w_run && !w_last && !w_dec_busy && (w_dec_cnt < LP_NUM)
                       && !w_bank_full[w_dec_bank];
        w_idct_issue = w_run && !w_last && !w_idct_busy && w_bank_full[w_idct_bank];
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= S_IDLE;
            r_bank_full  <= 2'b00;
            r_dec_busy   <= 1'b0;
            r_idct_busy  <= 1'b0;
            r_dec_bank   <= 1'b0;
            r_idct_bank  <= 1'b0;
            r_dec_cnt    <= '0;
            r_idct_cnt   <= '0;
            r_dec_start  <= 1'b0;
            r_idct_start <= 1'b0;
            r_finish     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dec_start  <= 1'b0;
            r_idct_start <= 1'b0;
            r_finish     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // NUM_BLOCKS >= 1, so the first decode can always be issued right away.
                    if (start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_bank_full <= 2'b00;
                        r_dec_bank  <= 1'b0;
                        r_idct_bank <= 1'b0;
                        r_dec_cnt   <= '0;
                        r_idct_cnt  <= '0;
                        r_idct_busy <= 1'b0;
                        r_dec_busy  <= 1'b1;
                        r_dec_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_bank_full  <= w_bank_full;
                    r_dec_bank   <= w_dec_bank;
                    r_idct_bank  <= w_idct_bank;
                    r_dec_cnt    <= w_dec_cnt;
                    r_idct_cnt   <= w_idct_cnt;
                    r_dec_busy   <= w_dec_busy | w_dec_issue;
                    r_idct_busy  <= w_idct_busy | w_idct_issue;
                    r_dec_start  <= w_dec_issue;
                    r_idct_start <= w_idct_issue;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign finish       = r_finish;
    assign dec_start    = r_dec_start;
    assign dec_bank     = r_dec_bank;
    assign dec_blk_idx  = r_dec_cnt;
    assign idct_start   = r_idct_start;
    assign idct_bank    = r_idct_bank;
    assign idct_blk_idx = r_idct_cnt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_m3_block_scheduler.sv
// Bench for m3_block_scheduler: a 4-block instance with fixed-latency engine models
// and a full-image instance with random engine latencies.
module tb_m3_block_scheduler;

    localparam int IW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- 4-block instance ----------------
    logic          s_start = 1'b0;
    logic          s_finish, s_dstart, s_dbank, s_istart, s_ibank, s_busy;
    logic [IW-1:0] s_didx, s_iidx;
    logic          s_edfin = 1'b0, s_eifin = 1'b0, sp_dfin = 1'b0, sp_ifin = 1'b0;
    logic          s_dfin, s_ifin;
    assign s_dfin = s_edfin | sp_dfin;
    assign s_ifin = s_eifin | sp_ifin;
    int s_dlat = 10;
    int s_ilat = 10;

    m3_block_scheduler #(.NUM_BLOCKS(4), .IDX_W(IW)) u_small (
        .Clock_50(clk), .Resetn(rst_n), .start(s_start), .finish(s_finish),
        .dec_start(s_dstart), .dec_finish(s_dfin), .dec_bank(s_dbank), .dec_blk_idx(s_didx),
        .idct_start(s_istart), .idct_finish(s_ifin), .idct_bank(s_ibank),
        .idct_blk_idx(s_iidx), .busy(s_busy)
    );

    // engine models: finish pulse L cycles after the start pulse
    initial begin
        int dc, ic;
        dc = 0; ic = 0;
        forever begin
            @(negedge clk);
            s_edfin = 1'b0; s_eifin = 1'b0;
            if (!rst_n) begin
                dc = 0; ic = 0;
            end else begin
                if (dc > 0) begin dc--; if (dc == 0) s_edfin = 1'b1; end
                if (ic > 0) begin ic--; if (ic == 0) s_eifin = 1'b1; end
                if (s_dstart) dc = s_dlat;
                if (s_istart) ic = s_ilat;
            end
        end
    end

    logic       mon_clr = 1'b0;
    int         cyc = 0, n_ds, n_is, n_if, n_fin, n_ovr, coin, fin_cyc, last_if, bsy_after, fin_busy;
    int         idx_err;
    int         ds_cyc[8], is_cyc[8], if_cyc[8];
    logic [3:0] ds_bank_v, is_bank_v;
    logic [1:0] m_full;
    logic       m_db, m_ib, prev_fin;

    initial begin
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (mon_clr || !rst_n) begin
                n_ds = 0; n_is = 0; n_if = 0; n_fin = 0; n_ovr = 0; coin = -1;
                fin_cyc = -1; last_if = -1; bsy_after = -1; fin_busy = -1; idx_err = 0;
                ds_bank_v = '0; is_bank_v = '0; m_full = '0; m_db = 0; m_ib = 0; prev_fin = 0;
                for (int i = 0; i < 8; i++) begin ds_cyc[i] = -1; is_cyc[i] = -1; if_cyc[i] = -1; end
            end else begin
                if (s_dstart) begin
                    if (n_ds < 8) ds_cyc[n_ds] = cyc;
                    if (n_ds < 4) ds_bank_v[n_ds] = s_dbank;
                    if (s_didx != IW'(n_ds)) idx_err++;
                    if (m_full[s_dbank]) n_ovr++;
                    m_db = 1'b1; n_ds++;
                end
                if (s_istart) begin
                    if (n_is < 8) is_cyc[n_is] = cyc;
                    if (n_is < 4) is_bank_v[n_is] = s_ibank;
                    if (s_iidx != IW'(n_is)) idx_err++;
                    m_ib = 1'b1; n_is++;
                end
                if (s_dfin && s_ifin && m_db && m_ib && coin < 0) coin = cyc;
                if (s_dfin && m_db) begin m_full[s_dbank] = 1'b1; m_db = 1'b0; end
                if (s_ifin && m_ib) begin
                    m_full[s_ibank] = 1'b0; m_ib = 1'b0;
                    if (n_if < 8) if_cyc[n_if] = cyc;
                    n_if++; last_if = cyc;
                end
                if (prev_fin) bsy_after = s_busy;
                prev_fin = s_finish;
                if (s_finish) begin n_fin++; fin_cyc = cyc; fin_busy = s_busy; end
            end
        end
    end

    // ---------------- full-image instance ----------------
    logic          b_start = 1'b0;
    logic          b_finish, b_dstart, b_dbank, b_istart, b_ibank, b_busy;
    logic [IW-1:0] b_didx, b_iidx;
    logic          b_dfin = 1'b0, b_ifin = 1'b0;

    m3_block_scheduler #(.NUM_BLOCKS(2400), .IDX_W(IW)) u_full (
        .Clock_50(clk), .Resetn(rst_n), .start(b_start), .finish(b_finish),
        .dec_start(b_dstart), .dec_finish(b_dfin), .dec_bank(b_dbank), .dec_blk_idx(b_didx),
        .idct_start(b_istart), .idct_finish(b_ifin), .idct_bank(b_ibank),
        .idct_blk_idx(b_iidx), .busy(b_busy)
    );

    initial begin
        int dc, ic;
        dc = 0; ic = 0;
        forever begin
            @(negedge clk);
            b_dfin = 1'b0; b_ifin = 1'b0;
            if (!rst_n) begin
                dc = 0; ic = 0;
            end else begin
                if (dc > 0) begin dc--; if (dc == 0) b_dfin = 1'b1; end
                if (ic > 0) begin ic--; if (ic == 0) b_ifin = 1'b1; end
                if (b_dstart) dc = int'($urandom_range(1, 16));
                if (b_istart) ic = int'($urandom_range(1, 16));
            end
        end
    end

    int   bn_ds = 0, bn_is = 0, bn_fin = 0, b_ord_err = 0, b_bsy_after = -1, b_fin_busy = -1;
    int   b_bank_err = 0;
    logic b_prev_fin = 1'b0;

    initial begin
        forever begin
            @(negedge clk); #1;
            if (b_dstart) begin
                if (b_didx != IW'(bn_ds)) b_ord_err++;
                if (b_dbank != bn_ds[0]) b_bank_err++;
                bn_ds++;
            end
            if (b_istart) begin
                if (b_iidx != IW'(bn_is)) b_ord_err++;
                if (b_ibank != bn_is[0]) b_bank_err++;
                bn_is++;
            end
            if (b_prev_fin) b_bsy_after = b_busy;
            b_prev_fin = b_finish;
            if (b_finish) begin bn_fin++; b_fin_busy = b_busy; end
        end
    end

    // ---------------- directed sequences ----------------
    task automatic clear_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic pulse_small_start();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
    endtask

    task automatic wait_small_finish();
        for (int k = 0; k < 3000 && n_fin == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] zero_vec;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        zero_vec = 32'({s_finish, s_dstart, s_dbank, s_didx, s_istart, s_ibank, s_iidx, s_busy});
        chk("reset_outputs", zero_vec, 0);
        rst_n = 1'b1;

        // Reset applied mid-run
        s_dlat = 10; s_ilat = 10;
        clear_mon();
        pulse_small_start();
        repeat (30) @(negedge clk);
        #2;
        chk("midrun_busy", 32'(s_busy), 1);
        chk("midrun_dec_idx", 32'(s_didx), 2);
        rst_n = 1'b0;
        #1;
        zero_vec = 32'({s_finish, s_dstart, s_dbank, s_didx, s_istart, s_ibank, s_iidx, s_busy});
        chk("async_reset_outputs", zero_vec, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); sp_dfin = 1'b1; sp_ifin = 1'b1;
        @(negedge clk); sp_dfin = 1'b0; sp_ifin = 1'b0;
        #2;
        chk("idle_spurious_busy", 32'(s_busy), 0);
        chk("idle_spurious_idx", 32'({s_didx, s_iidx}), 0);

        // 4 blocks, 10/10 latency
        clear_mon();
        pulse_small_start();
        wait_small_finish();
        chk("t2_dec_starts", n_ds, 4);
        chk("t2_idct_starts", n_is, 4);
        chk("t2_finish_count", n_fin, 1);
        chk("t2_dec_banks", 32'(ds_bank_v), 32'(4'b1010));
        chk("t2_idct_banks", 32'(is_bank_v), 32'(4'b1010));
        chk("t2_index_order", idx_err, 0);
        chk("t2_first_idct_start", is_cyc[0], ds_cyc[0] + 11);
        chk("t2_coincident_cycle", coin, ds_cyc[0] + 21);
        chk("t2_dec_after_coin", ds_cyc[2], coin + 1);
        chk("t2_idct_after_coin", is_cyc[1], coin + 1);
        chk("t2_finish_latency", fin_cyc, last_if + 1);
        chk("t2_busy_at_finish", fin_busy, 1);
        chk("t2_busy_after_finish", bsy_after, 0);
        chk("t2_no_overwrite", n_ovr, 0);

        // Slow IDCT: 5/40 latency
        s_dlat = 5; s_ilat = 40;
        clear_mon();
        pulse_small_start();
        wait_small_finish();
        chk("t3_dec_starts", n_ds, 4);
        chk("t3_second_dec", ds_cyc[1], ds_cyc[0] + 6);
        chk("t3_third_dec_withheld", ds_cyc[2], if_cyc[0] + 1);
        chk("t3_fourth_dec", ds_cyc[3], if_cyc[1] + 1);
        chk("t3_no_overwrite", n_ovr, 0);
        chk("t3_dec_banks", 32'(ds_bank_v), 32'(4'b1010));
        chk("t3_finish_latency", fin_cyc, last_if + 1);
        chk("t3_finish_count", n_fin, 1);

        // Spurious idct_finish and start during RUN
        s_dlat = 6; s_ilat = 6;
        clear_mon();
        pulse_small_start();
        @(negedge clk); sp_ifin = 1'b1; s_start = 1'b1;
        @(negedge clk); sp_ifin = 1'b0; s_start = 1'b0;
        #2;
        chk("t5_idct_idx_hold", 32'(s_iidx), 0);
        chk("t5_dec_idx_hold", 32'(s_didx), 0);
        chk("t5_no_extra_start", 32'({s_dstart, s_istart}), 0);
        chk("t5_start_count", n_ds + n_is, 1);
        wait_small_finish();
        chk("t5_dec_starts", n_ds, 4);
        chk("t5_idct_starts", n_is, 4);
        chk("t5_finish_count", n_fin, 1);
        chk("t5_index_order", idx_err, 0);

        // Full image, random latencies
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int k = 0; k < 90000 && bn_fin == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        chk("t6_dec_starts", bn_ds, 2400);
        chk("t6_idct_starts", bn_is, 2400);
        chk("t6_index_order", b_ord_err, 0);
        chk("t6_bank_alternation", b_bank_err, 0);
        chk("t6_finish_count", bn_fin, 1);
        chk("t6_busy_at_finish", b_fin_busy, 1);
        chk("t6_busy_after_finish", b_bsy_after, 0);
        chk("t6_final_idct_idx", 32'(b_iidx), 2400);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
